dct_coef_engine: RTL and testbench

//  Sequential 2-D DCT-II coefficient engine for one NxN block. It computes a single output

---
 rtl/dct_pkg.sv | 29 ++
 rtl/dct_cos_rom.sv | 37 +++
 rtl/dct_coef_engine.sv | 145 ++++++++++++++
 tb/tb_dct_coef_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared types, defaults and the elaboration-time cosine-product function for the DCT engine.
package dct_pkg;

  localparam int unsigned DCT_N_DEFAULT = 8;
  localparam real DCT_PI = 3.14159265358979323846;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} dct_state_t;

  // a(k1)*a(k2) is formed as sqrt(c1*c2)/N with c in {1,2} so that the DC and
  // all-AC scales are exact in floating point.
  function automatic int cos_term(input int n, input int frac_bits, input int k1, input int k2,
                                  input int n1, input int n2);
    real amp;
    real c1;
    real c2;
    real x;
    if (k1 == 0 && k2 == 0) amp = 1.0;
    else if (k1 == 0 || k2 == 0) amp = 1.4142135623730951;
    else amp = 2.0;
    amp = amp / real'(n);
    c1 = $cos(real'((2 * n1 + 1) * k1) * DCT_PI / real'(2 * n));
    c2 = $cos(real'((2 * n2 + 1) * k2) * DCT_PI / real'(2 * n));
    x = amp * c1 * c2 * real'(1 << frac_bits);
    // Truncate toward zero (e.g. (3,7,0,0) -> 0x029); the nudge absorbs float error on exact terms.
    if (x >= 0.0) return $rtoi(x + 1.0e-6);
    return -$rtoi(-x + 1.0e-6);
  endfunction

endpackage

// File: rtl/dct_cos_rom.sv
// Cosine-product ROM addressed by {k1,k2,n1,n2}; registered read with one cycle of latency.
module dct_cos_rom
  import dct_pkg::*;
#(
  parameter int unsigned N         = DCT_N_DEFAULT,
  parameter int unsigned COEF_W    = 12,
  parameter int unsigned FRAC_BITS = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [4*$clog2(N)-1:0]     addr,
  output logic signed [COEF_W-1:0]   data
);

  localparam int LOG_N = $clog2(N);
  localparam int DEPTH = 1 << (4 * LOG_N);
  localparam int NI    = int'(N);

  logic signed [COEF_W-1:0] rom_tbl [DEPTH];

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    localparam int K1 = (a >> (3 * LOG_N)) % NI;
    localparam int K2 = (a >> (2 * LOG_N)) % NI;
    localparam int N1 = (a >> LOG_N) % NI;
    localparam int N2 = a % NI;
    assign rom_tbl[a] = COEF_W'(cos_term(NI, int'(FRAC_BITS), K1, K2, N1, N2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      data <= rom_tbl[addr];
    end
  end

endmodule

// File: rtl/dct_coef_engine.sv
// Sequential 2-D DCT-II single-coefficient engine: streams an NxN block, returns rounded X(k1,k2).
module dct_coef_engine
  import dct_pkg::*;
#(
  parameter int unsigned N         = DCT_N_DEFAULT,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned COEF_W    = 12,
  parameter int unsigned FRAC_BITS = 10,
  parameter int unsigned ACC_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [$clog2(N)-1:0]      k1,
  input  logic [$clog2(N)-1:0]      k2,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_pixel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   out_coef,
  output logic                      busy
);

  localparam int unsigned LOG_N  = $clog2(N);
  localparam int unsigned IDX_W  = 2 * LOG_N;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1 << (FRAC_BITS - 1));

  dct_state_t state_q, state_d;

  logic [IDX_W-1:0]          idx_q;
  logic [LOG_N-1:0]          k1_q, k2_q;
  logic                      s1_valid_q, s2_valid_q;
  logic signed [DATA_W-1:0]  pix_s1_q;
  logic signed [COEF_W-1:0]  rom_data;
  logic signed [PROD_W-1:0]  prod_q;
  logic signed [ACC_W-1:0]   acc_q, acc_sum, out_coef_q;
  logic                      accept, start_ok, finish;

  assign accept = in_valid && (state_q == ACCUM);

  // idx is {n1,n2} because N is a power of two, so the ROM address is a plain concatenation.
  dct_cos_rom #(
    .N         (N),
    .COEF_W    (COEF_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  ({k1_q, k2_q, idx_q}),
    .data  (rom_data)
  );

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ACCUM;
          start_ok = 1'b1;
        end
      end
      ACCUM: begin
        if (accept && idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        // The last product sits in S2 with S1 empty: fold it in while loading the output.
        if (s2_valid_q && !s1_valid_q) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      start_ok = 1'b0;
      finish   = 1'b0;
    end
  end

  always_comb begin
    acc_sum = acc_q;
    if (s2_valid_q) acc_sum = acc_q + ACC_W'(prod_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      k1_q       <= '0;
      k2_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      pix_s1_q   <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      out_coef_q <= '0;
    end else if (abort) begin
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      if (start_ok) begin
        k1_q  <= k1;
        k2_q  <= k2;
        idx_q <= '0;
      end else if (accept) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      s1_valid_q <= accept;
      if (accept) pix_s1_q <= in_pixel;
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) prod_q <= PROD_W'(pix_s1_q) * PROD_W'(rom_data);
      if (start_ok) begin
        acc_q <= '0;
      end else if (s2_valid_q) begin
        acc_q <= acc_sum;
      end
      if (finish) out_coef_q <= (acc_sum + ROUND_BIAS) >>> FRAC_BITS;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_coef  = out_coef_q;

endmodule

// File: tb/tb_dct_coef_engine.sv
// Self-checking bench for dct_coef_engine: directed DCT cases plus a randomized (k1,k2) sweep.
module tb_dct_coef_engine;

  localparam int N  = 8;
  localparam int DW = 12;
  localparam int CW = 12;
  localparam int FB = 10;
  localparam int AW = 32;
  localparam real PI = 3.14159265358979323846;

  typedef logic signed [DW-1:0] pix_t;
  typedef pix_t block_t [64];

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [2:0] k1 = '0;
  logic [2:0] k2 = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  pix_t in_pixel = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [AW-1:0] out_coef;
  logic busy;

  int checks = 0;
  int failures = 0;
  int acc_count = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (in_valid && in_ready) acc_count <= acc_count + 1;

  dct_coef_engine #(
    .N         (N),
    .DATA_W    (DW),
    .COEF_W    (CW),
    .FRAC_BITS (FB),
    .ACC_W     (AW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .k1        (k1),
    .k2        (k2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .busy      (busy)
  );

  // Term = a(k1)a(k2)cos cos scaled by 2^10, truncated toward zero (ROM holds 0x029 for (3,7,0,0)).
  function automatic int ref_term(input int rk1, input int rk2, input int n1, input int n2);
    real a1, a2, x;
    a1 = (rk1 == 0) ? 1.0 : 1.4142135623730951;
    a2 = (rk2 == 0) ? 1.0 : 1.4142135623730951;
    if (rk1 != 0 && rk2 != 0) x = 2.0 / 8.0;
    else x = a1 * a2 / 8.0;
    x = x * $cos(PI * real'((2 * n1 + 1) * rk1) / 16.0) * $cos(PI * real'((2 * n2 + 1) * rk2) / 16.0);
    x = x * 1024.0;
    if (x >= 0.0) return $rtoi(x + 1.0e-6);
    return -$rtoi(-x + 1.0e-6);
  endfunction

  function automatic longint ref_coef(input int rk1, input int rk2, input block_t pix);
    longint s;
    s = 0;
    for (int p = 0; p < 64; p++) s += longint'(pix[p]) * longint'(ref_term(rk1, rk2, p / 8, p % 8));
    return (s + 512) >>> 10;
  endfunction

  // Runs one block; returns what was observed, comparisons are made by the callers.
  task automatic run_block(input int bk1, input int bk2, input block_t pix, input bit throttle,
                           input int hold, input bit noisy, output logic signed [AW-1:0] coef,
                           output int lat, output int accepts, output bit timed_out,
                           output bit stable, output bit idle_after);
    int p;
    int guard;
    int base;
    timed_out = 1'b0;
    stable = 1'b1;
    @(negedge clk);
    base = acc_count;
    start = 1'b1;
    k1 = 3'(bk1);
    k2 = 3'(bk2);
    @(negedge clk);
    start = 1'b0;
    p = 0;
    guard = 0;
    while (p < 64 && guard < 1000) begin
      in_valid = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_pixel = in_valid ? pix[p] : pix_t'($urandom);
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        k1 = 3'($urandom);
        k2 = 3'($urandom);
      end
      if (in_valid && in_ready) p++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 1000) timed_out = 1'b1;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) timed_out = 1'b1;
    coef = out_coef;
    for (int i = 0; i < hold; i++) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        k1 = 3'($urandom);
      end
      @(negedge clk);
      if (!out_valid || out_coef !== coef) stable = 1'b0;
    end
    out_ready = 1'b1;
    start = noisy;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    idle_after = !busy && !out_valid;
    accepts = acc_count - base;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_coef !== '0) begin failures++; $display("FAIL reset_out_coef: got %0d want 0", out_coef); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: busy=%b in_ready=%b out_valid=%b want 000", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_dc();
    block_t pix;
    logic signed [AW-1:0] c;
    int lat, acc;
    bit to, st, idl;
    foreach (pix[i]) pix[i] = 12'sd100;
    run_block(0, 0, pix, 1'b0, 0, 1'b0, c, lat, acc, to, st, idl);
    checks++; if (c !== 32'sd800) begin failures++; $display("FAIL dc_coef: got %0d want 800", c); end
    checks++; if (lat !== 3 || to) begin failures++; $display("FAIL dc_latency: got %0d cycles want 3", lat); end
    checks++; if (acc !== 64) begin failures++; $display("FAIL dc_accepts: got %0d want 64", acc); end
    checks++; if (idl !== 1'b1) begin failures++; $display("FAIL dc_idle_after: got %b want 1", idl); end
  endtask

  task automatic test_antisym();
    block_t pix;
    logic signed [AW-1:0] c;
    int lat, acc;
    bit to, st, idl;
    foreach (pix[i]) pix[i] = 12'sd100;
    run_block(3, 7, pix, 1'b0, 0, 1'b0, c, lat, acc, to, st, idl);
    checks++; if (c !== 32'sd0 || to) begin failures++; $display("FAIL antisym_coef: got %0d want 0", c); end
  endtask

  task automatic test_impulse();
    block_t pix;
    logic signed [AW-1:0] c;
    int lat, acc;
    bit to, st, idl;
    foreach (pix[i]) pix[i] = '0;
    pix[0] = 12'sd1000;
    run_block(3, 7, pix, 1'b0, 0, 1'b0, c, lat, acc, to, st, idl);
    checks++; if (c !== 32'sd40) begin failures++; $display("FAIL impulse_00: got %0d want 40", c); end
    foreach (pix[i]) pix[i] = '0;
    pix[2 * 8 + 3] = -12'sd1000;
    run_block(3, 7, pix, 1'b1, 0, 1'b0, c, lat, acc, to, st, idl);
    checks++; if (c !== -32'sd240) begin failures++; $display("FAIL impulse_23: got %0d want -240", c); end
  endtask

  task automatic test_flow_control();
    block_t pix;
    logic signed [AW-1:0] c;
    int lat, acc;
    bit to, st, idl;
    foreach (pix[i]) pix[i] = 12'sd100;
    run_block(0, 0, pix, 1'b1, 10, 1'b1, c, lat, acc, to, st, idl);
    checks++; if (c !== 32'sd800 || to) begin failures++; $display("FAIL flow_coef: got %0d want 800", c); end
    checks++; if (acc !== 64) begin failures++; $display("FAIL flow_accepts: got %0d want 64", acc); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL flow_stable: got %b want 1", st); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL flow_latency: got %0d want 3", lat); end
    checks++; if (idl !== 1'b1) begin failures++; $display("FAIL flow_start_on_handshake: idle=%b want 1", idl); end
  endtask

  task automatic test_abort();
    block_t pix;
    logic signed [AW-1:0] c;
    int lat, acc;
    bit to, st, idl, seen;
    @(negedge clk);
    start = 1'b1;
    k1 = '0;
    k2 = '0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_pixel = 12'sd100;
    for (int i = 0; i < 30; i++) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL abort_to_idle: busy=%b in_ready=%b want 00", busy, in_ready);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_over_start: busy=%b want 0", busy); end
    abort = 1'b0;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_output: activity=%b want 0", seen); end
    foreach (pix[i]) pix[i] = 12'sd100;
    run_block(0, 0, pix, 1'b0, 0, 1'b0, c, lat, acc, to, st, idl);
    checks++; if (c !== 32'sd800 || to) begin failures++; $display("FAIL abort_clean_coef: got %0d want 800", c); end
    checks++; if (acc !== 64) begin failures++; $display("FAIL abort_clean_accepts: got %0d want 64", acc); end
  endtask

  task automatic test_reset_mid();
    block_t pix;
    logic signed [AW-1:0] c;
    int lat, acc;
    bit to, st, idl, seen;
    @(negedge clk);
    start = 1'b1;
    k1 = 3'd3;
    k2 = 3'd7;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_pixel = 12'sd555;
    for (int i = 0; i < 20; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    checks++; if (out_coef !== '0) begin failures++; $display("FAIL rstmid_out_coef: got %0d want 0", out_coef); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_output: activity=%b want 0", seen); end
    foreach (pix[i]) pix[i] = '0;
    pix[0] = 12'sd1000;
    run_block(3, 7, pix, 1'b0, 0, 1'b0, c, lat, acc, to, st, idl);
    checks++; if (c !== 32'sd40 || to) begin failures++; $display("FAIL rstmid_clean_coef: got %0d want 40", c); end
  endtask

  task automatic test_sweep();
    block_t pix;
    logic signed [AW-1:0] c;
    logic signed [AW-1:0] want;
    int lat, acc;
    bit to, st, idl;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        foreach (pix[i]) pix[i] = pix_t'($urandom_range(0, 4095));
        want = AW'(ref_coef(a, b, pix));
        run_block(a, b, pix, ((a + b) % 3) == 0, 0, 1'b0, c, lat, acc, to, st, idl);
        checks++;
        if (c !== want || to) begin
          failures++; $display("FAIL sweep_k%0d%0d: got %0d want %0d", a, b, c, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_antisym();
    test_impulse();
    test_flow_control();
    test_abort();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
